// File: rtl/pkt_snoop_pkg.sv
// Shared types and constants for the packet snooper's length-counting stage.
// The default record layout matches a 16-bit length field.
package pkt_snoop_pkg;

    localparam int REC_FIFO_DEPTH = 2;
    localparam int PKT_LEN_W_DEFAULT = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_len_state_e;

    typedef struct packed {
        logic                         ovf;
        logic [PKT_LEN_W_DEFAULT-1:0] len;
    } pkt_len_rec_t;

endpackage

// File: rtl/pkt_len_rec_fifo.sv
// Small record FIFO for per-packet length records. A push while full succeeds only
// when a pop happens in the same cycle. The drop pulse exists only with PKT_SNOOP_DROP_CNT_EN.
module pkt_len_rec_fifo
    import pkt_snoop_pkg::*;
#(
    parameter type rec_t = pkt_len_rec_t
) (
    input  logic clk,
    input  logic aresetn,
    input  logic push,
    input  rec_t push_data,
    input  logic pop,
    output rec_t head,
    output logic empty,
`ifdef PKT_SNOOP_DROP_CNT_EN
    output logic dropped,
`endif
    output logic full
);

    localparam int PTR_W = (REC_FIFO_DEPTH > 1) ? $clog2(REC_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(REC_FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(REC_FIFO_DEPTH);

    rec_t             r_mem [REC_FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign full      = (r_count == CNT_FULL);
    assign empty     = (r_count == '0);
    assign w_pop_ok  = pop && !empty;
    // When full, the slot being pushed is the head being popped on this same edge.
    assign w_push_ok = push && (!full || w_pop_ok);
    assign head      = r_mem[r_rd_ptr];

`ifdef PKT_SNOOP_DROP_CNT_EN
    assign dropped = push && !w_push_ok;
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < REC_FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_length_counter.sv
// Per-packet byte accumulation with a length-record valid/ready output and link totals.
// PKT_SNOOP_DROP_CNT_EN builds the dropped-record counter; otherwise dropped_recs is 0.
module packet_length_counter
    import pkt_snoop_pkg::*;
#(
    parameter int LEN_WIDTH = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 snoop_valid,
    input  logic                 snoop_last,
    input  logic [7:0]           bytes_in_flit,
    input  logic                 clear,
    output logic [LEN_WIDTH-1:0] pkt_len,
    output logic                 pkt_ovf,
    output logic                 pkt_len_valid,
    input  logic                 pkt_len_ready,
    output logic [CNT_WIDTH-1:0] total_bytes,
    output logic [CNT_WIDTH-1:0] total_pkts,
    output logic [15:0]          dropped_recs,
    output logic                 dbg_state
);

    typedef struct packed {
        logic                 ovf;
        logic [LEN_WIDTH-1:0] len;
    } rec_t;

    localparam int SUM_W = LEN_WIDTH + 9;
    localparam logic [SUM_W-1:0] LEN_MAX = {9'b0, {LEN_WIDTH{1'b1}}};

    logic                 r_d_valid;
    logic                 r_d_last;
    pkt_len_state_e       r_state;
    pkt_len_state_e       w_state_nxt;
    logic [LEN_WIDTH-1:0] r_acc;
    logic                 r_ovf;
    logic [CNT_WIDTH-1:0] r_total_bytes;
    logic [CNT_WIDTH-1:0] r_total_pkts;

    logic [SUM_W-1:0]     w_base;
    logic [SUM_W-1:0]     w_sum;
    logic                 w_sat;
    logic [LEN_WIDTH-1:0] w_len;
    logic                 w_ovf;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_full;
    rec_t                 w_rec;
    rec_t                 w_head;

    // Delay the handshake one cycle so it lines up with the registered byte count.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_d_valid <= 1'b0;
            r_d_last  <= 1'b0;
        end else begin
            r_d_valid <= snoop_valid;
            r_d_last  <= snoop_last;
        end
    end

    assign w_base = (r_state == IDLE) ? '0 : {9'b0, r_acc};
    assign w_sum  = w_base + {{(LEN_WIDTH + 1){1'b0}}, bytes_in_flit};
    assign w_sat  = (w_sum > LEN_MAX);
    assign w_len  = w_sat ? {LEN_WIDTH{1'b1}} : w_sum[LEN_WIDTH-1:0];
    assign w_ovf  = ((r_state == IN_PKT) && r_ovf) || w_sat;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        if (r_d_valid) begin
            w_state_nxt = r_d_last ? IDLE : IN_PKT;
            w_push      = r_d_last;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (r_d_valid) begin
            r_acc <= w_len;
            r_ovf <= w_ovf;
        end
    end

    // Clear takes priority over a coincident beat, which is then not counted.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_total_bytes <= '0;
            r_total_pkts  <= '0;
        end else if (clear) begin
            r_total_bytes <= '0;
            r_total_pkts  <= '0;
        end else if (r_d_valid) begin
            r_total_bytes <= r_total_bytes + {{(CNT_WIDTH - 8){1'b0}}, bytes_in_flit};
            r_total_pkts  <= r_total_pkts + {{(CNT_WIDTH - 1){1'b0}}, r_d_last};
        end
    end

    assign w_rec.ovf = w_ovf;
    assign w_rec.len = w_len;
    assign w_pop     = pkt_len_valid && pkt_len_ready;

`ifdef PKT_SNOOP_DROP_CNT_EN
    logic        w_dropped;
    logic [15:0] r_dropped_recs;
`endif

    pkt_len_rec_fifo #(
        .rec_t(rec_t)
    ) u_rec_fifo (
        .clk      (clk),
        .aresetn  (aresetn),
        .push     (w_push),
        .push_data(w_rec),
        .pop      (w_pop),
        .head     (w_head),
        .empty    (w_empty),
`ifdef PKT_SNOOP_DROP_CNT_EN
        .dropped  (w_dropped),
`endif
        .full     (w_full)
    );

`ifdef PKT_SNOOP_DROP_CNT_EN
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_dropped_recs <= '0;
        end else if (clear) begin
            r_dropped_recs <= '0;
        end else if (w_dropped && (r_dropped_recs != 16'hFFFF)) begin
            r_dropped_recs <= r_dropped_recs + 16'd1;
        end
    end
    assign dropped_recs = r_dropped_recs;
`else
    assign dropped_recs = '0;
`endif

    assign pkt_len       = w_head.len;
    assign pkt_ovf       = w_head.ovf;
    assign pkt_len_valid = !w_empty;
    assign total_bytes   = r_total_bytes;
    assign total_pkts    = r_total_pkts;
    assign dbg_state     = (r_state == IN_PKT) || w_full;

endmodule

// File: tb/tb_packet_length_counter.sv
// Directed bench for packet_length_counter with LEN_WIDTH=8 so saturation is reachable.
// The byte count is supplied one cycle after the beat, as the upstream stage does.
module tb_packet_length_counter;

    localparam int LW = 8;
    localparam int CW = 32;

    logic          clk;
    logic          aresetn;
    logic          snoop_valid;
    logic          snoop_last;
    logic [7:0]    bytes_in_flit;
    logic [7:0]    nxt_bytes;
    logic          clear;
    logic [LW-1:0] pkt_len;
    logic          pkt_ovf;
    logic          pkt_len_valid;
    logic          pkt_len_ready;
    logic [CW-1:0] total_bytes;
    logic [CW-1:0] total_pkts;
    logic [15:0]   dropped_recs;
    logic          dbg_state;

    int n_checks;
    int n_fail;

    packet_length_counter #(
        .LEN_WIDTH(LW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .snoop_valid  (snoop_valid),
        .snoop_last   (snoop_last),
        .bytes_in_flit(bytes_in_flit),
        .clear        (clear),
        .pkt_len      (pkt_len),
        .pkt_ovf      (pkt_ovf),
        .pkt_len_valid(pkt_len_valid),
        .pkt_len_ready(pkt_len_ready),
        .total_bytes  (total_bytes),
        .total_pkts   (total_pkts),
        .dropped_recs (dropped_recs),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream byte-count stage: registered one cycle behind the beat.
    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) bytes_in_flit <= 8'd0;
        else          bytes_in_flit <= snoop_valid ? nxt_bytes : 8'd0;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Present one accepted beat for one cycle; returns #1 after the edge that samples it.
    task automatic send_beat(input logic [7:0] b, input logic last);
        snoop_valid = 1'b1;
        snoop_last  = last;
        nxt_bytes   = b;
        @(posedge clk);
        #1;
        snoop_valid = 1'b0;
        snoop_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        snoop_valid = 1'b0;
        snoop_last  = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        aresetn       = 1'b0;
        snoop_valid   = 1'b0;
        snoop_last    = 1'b0;
        nxt_bytes     = 8'd0;
        clear         = 1'b0;
        pkt_len_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_len", 32'(pkt_len), 0);
        check("rst_ovf", 32'(pkt_ovf), 0);
        check("rst_valid", 32'(pkt_len_valid), 0);
        check("rst_tbytes", total_bytes, 0);
        check("rst_tpkts", total_pkts, 0);
        check("rst_dropped", 32'(dropped_recs), 0);
        aresetn = 1'b1;
        idle(1);

        // Single-beat packet
        send_beat(8'd4, 1'b1);
        check("t1_early_valid", 32'(pkt_len_valid), 0);
        idle(1);
        check("t1_valid", 32'(pkt_len_valid), 1);
        check("t1_len", 32'(pkt_len), 4);
        check("t1_ovf", 32'(pkt_ovf), 0);
        check("t1_tpkts", total_pkts, 1);
        check("t1_tbytes", total_bytes, 4);
        idle(1);
        check("t1_popped", 32'(pkt_len_valid), 0);

        // Three-beat packet 4,4,3
        pulse_clear();
        check("clr_tbytes", total_bytes, 0);
        send_beat(8'd4, 1'b0);
        send_beat(8'd4, 1'b0);
        check("t2_nrec_a", 32'(pkt_len_valid), 0);
        check("t2_in_pkt", 32'(dbg_state), 1);
        send_beat(8'd3, 1'b1);
        check("t2_nrec_b", 32'(pkt_len_valid), 0);
        idle(1);
        check("t2_valid", 32'(pkt_len_valid), 1);
        check("t2_len", 32'(pkt_len), 11);
        check("t2_tbytes", total_bytes, 11);
        check("t2_tpkts", total_pkts, 1);
        idle(1);

        // Saturation: 70 beats of 4 bytes
        pulse_clear();
        for (int i = 0; i < 70; i++) send_beat(8'd4, (i == 69));
        idle(1);
        check("t3_len", 32'(pkt_len), 255);
        check("t3_ovf", 32'(pkt_ovf), 1);
        check("t3_tbytes", total_bytes, 280);
        idle(1);
        send_beat(8'd2, 1'b1);
        idle(1);
        check("t3b_len", 32'(pkt_len), 2);
        check("t3b_ovf", 32'(pkt_ovf), 0);
        idle(1);

        // Back-to-back records with ready held high
        send_beat(8'd5, 1'b1);
        send_beat(8'd6, 1'b1);
        check("b2b_len5", 32'(pkt_len), 5);
        send_beat(8'd7, 1'b1);
        check("b2b_len6", 32'(pkt_len), 6);
        idle(1);
        check("b2b_len7", 32'(pkt_len), 7);
        check("b2b_valid7", 32'(pkt_len_valid), 1);
        idle(1);
        check("b2b_empty", 32'(pkt_len_valid), 0);

        // FIFO full with ready low: records 3 and 4 are dropped
        pulse_clear();
        pkt_len_ready = 1'b0;
        send_beat(8'd1, 1'b1);
        send_beat(8'd2, 1'b1);
        send_beat(8'd3, 1'b1);
        send_beat(8'd4, 1'b1);
        idle(3);
        check("t4_valid", 32'(pkt_len_valid), 1);
        check("t4_hold_len", 32'(pkt_len), 1);
        check("t4_tpkts", total_pkts, 4);
        check("t4_tbytes", total_bytes, 10);
`ifdef PKT_SNOOP_DROP_CNT_EN
        check("t4_dropped", 32'(dropped_recs), 2);
`else
        check("t4_dropped", 32'(dropped_recs), 0);
`endif
        pkt_len_ready = 1'b1;
        idle(1);
        check("t4_len2", 32'(pkt_len), 2);
        check("t4_valid2", 32'(pkt_len_valid), 1);
        idle(1);
        check("t4_drained", 32'(pkt_len_valid), 0);

        // Reset in the middle of a packet
        send_beat(8'd9, 1'b0);
        send_beat(8'd9, 1'b0);
        idle(1);
        check("t5_in_pkt", 32'(dbg_state), 1);
        aresetn = 1'b0;
        #2;
        check("t5_rst_tbytes", total_bytes, 0);
        check("t5_rst_state", 32'(dbg_state), 0);
        aresetn = 1'b1;
        idle(1);
        send_beat(8'd3, 1'b1);
        idle(1);
        check("t5_len", 32'(pkt_len), 3);
        check("t5_tbytes", total_bytes, 3);
        check("t5_tpkts", total_pkts, 1);
        idle(1);

        // Clear on the same cycle as the aligned beat
        send_beat(8'd4, 1'b1);
        pulse_clear();
        check("t6_tbytes", total_bytes, 0);
        check("t6_tpkts", total_pkts, 0);
        check("t6_valid", 32'(pkt_len_valid), 1);
        check("t6_len", 32'(pkt_len), 4);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/packet_length_counter.md
# packet_length_counter

Consumes the per-beat byte count produced by the tkeep-to-byte-count stage of the packet snooper and the snooped AXI-Stream handshake of the monitored link. It accumulates bytes per packet and emits one length record per packet through a valid/ready interface. It also keeps running link totals of bytes and packets. It sits directly downstream of the byte-count stage and feeds the traffic monitor's statistics logic.

## Interface
- LEN_WIDTH, 16, width of per-packet length field
- CNT_WIDTH, 32, width of running total counters
- clk  in  1  clock
- aresetn  in  1  reset; asynchronous, active-low
- snoop_valid  in  1  monitored link beat accepted this cycle (tvalid && tready)
- snoop_last  in  1  tlast of that beat
- bytes_in_flit  in  8  byte count of a beat, valid one cycle after the beat (registered upstream)
- clear  in  1  synchronous clear of total_bytes, total_pkts, dropped_recs
- pkt_len  out  LEN_WIDTH  packet length in bytes, saturated
- pkt_ovf  out  1  packet length saturated
- pkt_len_valid  out  1  record available
- pkt_len_ready  in  1  consumer accepts record
- total_bytes  out  CNT_WIDTH  bytes seen since reset/clear
- total_pkts  out  CNT_WIDTH  packets completed since reset/clear
- dropped_recs  out  16  records lost because the record FIFO was full

## Operation
- Alignment:
  - snoop_valid and snoop_last are registered once (d_valid, d_last) so they line up with bytes_in_flit.
  - All accounting uses the aligned beat (d_valid).
- FSM states:
  - IDLE: no packet open. An aligned beat loads acc = bytes_in_flit. If d_last is set, a record is emitted and the FSM stays IDLE; otherwise it moves to IN_PKT.
  - IN_PKT: each aligned beat adds to acc. On d_last, a record is pushed and the FSM returns to IDLE.
- Length arithmetic:
  - bytes_in_flit is zero-extended before adding.
  - The sum saturates at 2^LEN_WIDTH-1.
  - A sticky ovf is set on saturation and cleared when a new packet starts.
  - A 0-byte beat counts as a beat that adds 0.
- Totals:
  - total_bytes += bytes_in_flit on each aligned beat.
  - total_pkts += 1 on each aligned last beat.
  - Both wrap modulo 2^CNT_WIDTH.
  - If clear and an aligned beat occur in the same cycle, clear wins; that beat is not counted.
  - clear has no effect on acc, the FSM, or the FIFO.
- Record FIFO: 2 entries of {ovf, len}.
  - The head entry drives pkt_len and pkt_ovf.
  - pkt_len_valid = not empty.
  - Pop on pkt_len_valid && pkt_len_ready.
  - A push while full is accepted only if a pop happens in the same cycle. Otherwise the record is dropped and dropped_recs increments, saturating at 0xFFFF.
  - Push and pop on a non-full, non-empty FIFO happen together and the occupancy is unchanged.
  - Records are emitted in packet order.
- Reset mid-packet:
  - All state clears and the FSM returns to IDLE.
  - Remaining beats of the interrupted packet are counted as a new packet, ending at the next last.

## Timing
- Reset values: every output is 0, including pkt_len_valid and dropped_recs. FIFO empty, FSM IDLE, acc 0, d_valid/d_last 0.
- Beat accepted in cycle N → its bytes are accounted on the clock edge ending cycle N+1.
- total_bytes reflects that beat in cycle N+2.
- Last beat in cycle N → pkt_len_valid high and total_pkts updated in cycle N+2.
- Back-to-back packets: one record per cycle is sustainable when pkt_len_ready is held high.
- pkt_len, pkt_ovf and pkt_len_valid are registered and stable while valid && !ready.

## Configuration
- PKT_SNOOP_DROP_CNT_EN
  - Defined: the dropped_recs counter is built as described above.
  - Undefined: the counter logic is omitted and dropped_recs is tied to 0. Record dropping on overflow still happens.

## Structure
- Package pkt_snoop_pkg holds:
  - enum pkt_len_state_e {IDLE, IN_PKT}
  - struct pkt_len_rec_t {ovf, len}
  - localparam REC_FIFO_DEPTH = 2
- Sub-module pkt_len_rec_fifo: a 2-entry FIFO of pkt_len_rec_t with full/empty flags and push-while-full-with-pop support.

## Test plan
- Single-beat packet, bytes 4, ready=1 → pkt_len=4, ovf=0 in cycle N+2; total_pkts=1, total_bytes=4.
- 3-beat packet, bytes 4,4,3, ready=1 → one record pkt_len=11; total_bytes=11; no record before the last beat.
- LEN_WIDTH=8, 70 beats of 4 bytes → pkt_len=255, pkt_ovf=1; the next 1-beat packet of 2 bytes → pkt_len=2, ovf=0.
- ready=0, four 1-beat packets of 1,2,3,4 bytes → records 1 and 2 are held and dropped_recs=2. Then with ready=1 the outputs are 1, then 2, then valid falls. With the macro undefined, dropped_recs stays 0.
- aresetn pulsed after 2 beats of a packet, then 1 beat with last, bytes 3 → record pkt_len=3; all totals restart from 0.
- clear coincident with an aligned beat of 4 bytes → total_bytes=0 afterward; the packet record is still correct.
